// File: rtl/alu_result_tx.sv
// Buffers ALU result words in a small FIFO and hands them to a consumer over a valid/ready handshake.
// Optional macro ALU_RESULT_TX_PARITY_EN adds an even-parity bit per entry and the EX_ALU_PAR output.
module alu_result_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RES_IN,
  input  logic                  RES_IN_VLD,
  output logic                  RES_IN_RDY,
  output logic [DATA_WIDTH-1:0] EX_ALU,
  output logic                  EX_ALU_VLD,
  input  logic                  EX_ALU_RDY,
  output logic [15:0]           TX_COUNT,
  output logic                  DROP
`ifdef ALU_RESULT_TX_PARITY_EN
  ,
  output logic                  EX_ALU_PAR
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef ALU_RESULT_TX_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int ENTRY_W = DATA_WIDTH + PAR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t             state_q;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   remaining;
  logic [ENTRY_W-1:0] exEntry_q, exEntry_d;
  logic               exVld_q;
  logic [15:0]        txCount_q;
  logic               drop_q;
  logic [ENTRY_W-1:0] entryIn;
  logic               push;
  logic               pop;

`ifdef ALU_RESULT_TX_PARITY_EN
  assign entryIn = {^RES_IN, RES_IN};
`else
  assign entryIn = RES_IN;
`endif

  assign RES_IN_RDY = (count_q < DEPTH_C);
  assign push       = RES_IN_VLD && RES_IN_RDY;
  assign pop        = exVld_q && EX_ALU_RDY;

  // The output register always holds the oldest entry; a push into an empty
  // (or just-emptied) buffer bypasses the array so it shows up one cycle later.
  always_comb begin
    remaining = pop  ? count_q - 1'b1 : count_q;
    count_d   = push ? remaining + 1'b1 : remaining;
    rdPtr_d   = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
    wrPtr_d   = push ? wrPtr_q + 1'b1 : wrPtr_q;
    if (count_d == '0) begin
      exEntry_d = '0;
    end else if (remaining == '0) begin
      exEntry_d = entryIn;
    end else begin
      exEntry_d = mem_q[rdPtr_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      exEntry_q <= '0;
      exVld_q   <= 1'b0;
      txCount_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= entryIn;
      end
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      exEntry_q <= exEntry_d;
      exVld_q   <= (count_d != '0);
      if (pop) begin
        txCount_q <= txCount_q + 16'd1;
      end
      if (RES_IN_VLD && !RES_IN_RDY) begin
        drop_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (push) state_q <= SEND;
        SEND: begin
          if (pop && !push && count_q == ONE_C) begin
            state_q <= IDLE;
          end else if (push && !pop && count_q == DEPTH_C - ONE_C) begin
            state_q <= FULL;
          end
        end
        FULL: if (pop) state_q <= SEND;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign EX_ALU     = exEntry_q[DATA_WIDTH-1:0];
  assign EX_ALU_VLD = exVld_q;
  assign TX_COUNT   = txCount_q;
  assign DROP       = drop_q;
`ifdef ALU_RESULT_TX_PARITY_EN
  assign EX_ALU_PAR = exEntry_q[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_alu_result_tx.sv
// Self-checking bench for alu_result_tx: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alu_result_tx;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        RST;
  logic [7:0]  RES_IN;
  logic        RES_IN_VLD;
  logic        RES_IN_RDY;
  logic [7:0]  EX_ALU;
  logic        EX_ALU_VLD;
  logic        EX_ALU_RDY;
  logic [15:0] TX_COUNT;
  logic        DROP;
`ifdef ALU_RESULT_TX_PARITY_EN
  logic        EX_ALU_PAR;
`endif

  alu_result_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .RES_IN(RES_IN),
    .RES_IN_VLD(RES_IN_VLD),
    .RES_IN_RDY(RES_IN_RDY),
    .EX_ALU(EX_ALU),
    .EX_ALU_VLD(EX_ALU_VLD),
    .EX_ALU_RDY(EX_ALU_RDY),
    .TX_COUNT(TX_COUNT),
    .DROP(DROP)
`ifdef ALU_RESULT_TX_PARITY_EN
    ,
    .EX_ALU_PAR(EX_ALU_PAR)
`endif
  );

  int compared = 0;
  int mismatched = 0;
  bit checkEn = 0;

  logic [7:0]  mq[$];
  logic [15:0] mTx;
  logic        mDrop;
  logic [7:0]  seen[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, log the handshake the DUT completes, and return at the next negedge.
  task automatic applyStimulus(input logic vld, input logic [7:0] data, input logic rdy);
    RES_IN_VLD = vld;
    RES_IN     = data;
    EX_ALU_RDY = rdy;
    #1;
    if (EX_ALU_VLD === 1'b1 && rdy) seen.push_back(EX_ALU);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reference model: a plain FIFO queue updated with the rules of accept, deliver, count and drop.
  always @(posedge CLK) begin
    if (RST) begin
      mq.delete();
      mTx   = 16'h0;
      mDrop = 1'b0;
    end else begin
      bit canPush;
      bit doPop;
      canPush = (mq.size() < DEPTH);
      doPop   = (mq.size() > 0) && EX_ALU_RDY;
      if (RES_IN_VLD && !canPush) mDrop = 1'b1;
      if (doPop) begin
        void'(mq.pop_front());
        mTx = mTx + 16'd1;
      end
      if (RES_IN_VLD && canPush) mq.push_back(RES_IN);
    end
  end

  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("model_rdy", RES_IN_RDY, mq.size() < DEPTH);
      checkOutput("model_vld", EX_ALU_VLD, mq.size() != 0);
      if (mq.size() != 0) begin
        checkOutput("model_data", EX_ALU, mq[0]);
`ifdef ALU_RESULT_TX_PARITY_EN
        checkOutput("model_par", EX_ALU_PAR, ^mq[0]);
`endif
      end
      checkOutput("model_tx", TX_COUNT, mTx);
      checkOutput("model_drop", DROP, mDrop);
    end
  end

  task automatic doReset();
    RST = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkEn = 1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    RST = 1'b0;
  endtask

  initial begin
    RST        = 1'b1;
    RES_IN     = '0;
    RES_IN_VLD = 1'b0;
    EX_ALU_RDY = 1'b0;

    // Reset values and ready immediately after release
    doReset();
    checkOutput("rst_vld", EX_ALU_VLD, 1'b0);
    checkOutput("rst_data", EX_ALU, 8'h00);
    checkOutput("rst_tx", TX_COUNT, 16'h0000);
    checkOutput("rst_drop", DROP, 1'b0);
    #1;
    checkOutput("rst_rdy_after", RES_IN_RDY, 1'b1);

    // Single result, one-cycle latency, immediate handshake
    applyStimulus(1'b1, 8'h3C, 1'b1);
    checkOutput("lat_data", EX_ALU, 8'h3C);
    checkOutput("lat_vld", EX_ALU_VLD, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("lat_tx", TX_COUNT, 16'h0001);
    checkOutput("lat_idle", EX_ALU_VLD, 1'b0);

    // Streaming with pointer wrap: one entry held at a time
    seen.delete();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'h10 + 8'(i), 1'b1);
      checkOutput("stream_head", EX_ALU, 8'h10 + 8'(i));
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("stream_n", seen.size(), 10);
    for (int i = 0; i < 10 && i < seen.size(); i++) checkOutput("stream_order", seen[i], 8'h10 + 8'(i));
    checkOutput("stream_drop", DROP, 1'b0);
    checkOutput("stream_tx", TX_COUNT, 16'd11);

    // Fill to full with consumer stalled, overflow sets DROP, then drain in order
    seen.delete();
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("full_rdy", RES_IN_RDY, 1'b0);
    checkOutput("full_head", EX_ALU, 8'h01);
    applyStimulus(1'b1, 8'h05, 1'b0);
    checkOutput("full_drop", DROP, 1'b1);
    checkOutput("full_stable", EX_ALU, 8'h01);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain_n", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) checkOutput("drain_order", seen[i], 8'(i + 1));
    checkOutput("drain_tx", TX_COUNT, 16'd15);

    // Push while full is rejected even if a pop happens in the same cycle
    seen.delete();
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'h20 + 8'(i), 1'b0);
    applyStimulus(1'b1, 8'h25, 1'b1);
    checkOutput("fullpop_head", EX_ALU, 8'h22);
    checkOutput("fullpop_rdy", RES_IN_RDY, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("fullpop_n", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) checkOutput("fullpop_order", seen[i], 8'h21 + 8'(i));

    // Reset mid-operation discards buffered entries
    applyStimulus(1'b1, 8'h31, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0);
    RST = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    RST = 1'b0;
    checkOutput("midrst_vld", EX_ALU_VLD, 1'b0);
    checkOutput("midrst_tx", TX_COUNT, 16'h0000);
    checkOutput("midrst_drop", DROP, 1'b0);
    checkOutput("midrst_rdy", RES_IN_RDY, 1'b1);
    seen.delete();
    applyStimulus(1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("midrst_n", seen.size(), 1);
    if (seen.size() > 0) checkOutput("midrst_val", seen[0], 8'hAA);

`ifdef ALU_RESULT_TX_PARITY_EN
    applyStimulus(1'b1, 8'h07, 1'b0);
    checkOutput("par_07", EX_ALU_PAR, 1'b1);
    applyStimulus(1'b1, 8'h03, 1'b1);
    checkOutput("par_03_data", EX_ALU, 8'h03);
    checkOutput("par_03", EX_ALU_PAR, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
`endif

    // Transfer counter wrap
    doReset();
    for (int i = 0; i < 65535; i++) applyStimulus(1'b1, 8'(i), 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("tx_ffff", TX_COUNT, 16'hFFFF);
    applyStimulus(1'b1, 8'h5A, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("tx_wrap", TX_COUNT, 16'h0000);

    checkEn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
